// File: rtl/riscv_pc_unit_if.sv
// Fetch request channel between the PC unit (master) and the instruction memory (slave).
interface riscv_pc_unit_if #(
    parameter int unsigned WORD_LENGTH = 32
) ();
    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [WORD_LENGTH-1:0] fetch_addr;

    modport master (
        output fetch_valid,
        output fetch_addr,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_addr,
        output fetch_ready
    );
endinterface

// File: rtl/riscv_pc_unit.sv
// Program-counter unit with valid/ready fetch port, trap/mret redirection and stall support.
// Optional misaligned-target exception: define RISCV_PC_MISALIGN_EN.
module riscv_pc_unit #(
    parameter int unsigned           WORD_LENGTH     = 32,
    parameter int unsigned           PC_OFFSET       = 4,
    parameter logic [WORD_LENGTH-1:0] RESET_VECTOR   = '0,
    parameter int unsigned           ALIGN_BITS      = 2,
    parameter int unsigned           PC_SEL_W        = 2,
    parameter logic [PC_SEL_W-1:0]   PC_ALU          = PC_SEL_W'(1),
    parameter logic [PC_SEL_W-1:0]   PC_B_TARGET     = PC_SEL_W'(2),
    parameter logic [PC_SEL_W-1:0]   PC_ECALL_TARGET = PC_SEL_W'(3)
) (
    input  logic                   clk,
    input  logic                   x_reset,
    input  logic                   stall,
    input  logic [PC_SEL_W-1:0]    pc_sel,
    input  logic [WORD_LENGTH-1:0] alu_out,
    input  logic [WORD_LENGTH-1:0] imm_b_sext,
    input  logic                   br_flag,
    input  logic [WORD_LENGTH-1:0] mtvec_addr,
    input  logic [WORD_LENGTH-1:0] mepc_addr,
    input  logic                   trap_req,
    input  logic                   mret_req,
    riscv_pc_unit_if.master        fetch_port,
    output logic [WORD_LENGTH-1:0] pc_plus4,
    output logic                   exc_misaligned,
    output logic [WORD_LENGTH-1:0] exc_badaddr
);

    localparam logic [WORD_LENGTH-1:0] ALIGN_MASK =
        ~((WORD_LENGTH'(1) << ALIGN_BITS) - WORD_LENGTH'(1));
    localparam logic [WORD_LENGTH-1:0] STEP = WORD_LENGTH'(PC_OFFSET);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q;
    logic [WORD_LENGTH-1:0] pc_q;
    logic                   fetch_valid_q;

    logic                   accept_s;
    logic                   event_s;
    logic [WORD_LENGTH-1:0] event_target_s;
    logic [WORD_LENGTH-1:0] event_pc_s;
    logic [WORD_LENGTH-1:0] flow_target_s;
    logic [WORD_LENGTH-1:0] flow_pc_s;
    logic                   flow_bad_s;
    logic [WORD_LENGTH-1:0] pc_d;

    // Redirect target selection; trap beats mret, both beat the pc_sel sources.
    always_comb begin
        accept_s       = fetch_valid_q & fetch_port.fetch_ready & ~stall;
        event_s        = trap_req | mret_req;
        event_target_s = trap_req ? mtvec_addr : mepc_addr;
        case (pc_sel)
            PC_ALU:          flow_target_s = alu_out & ~WORD_LENGTH'(1);
            PC_B_TARGET:     flow_target_s = br_flag ? (pc_q + imm_b_sext) : (pc_q + STEP);
            PC_ECALL_TARGET: flow_target_s = mtvec_addr;
            default:         flow_target_s = pc_q + STEP;
        endcase
`ifdef RISCV_PC_MISALIGN_EN
        // Trap/mret targets are trusted; only flow targets are checked.
        flow_bad_s = |(flow_target_s & ~ALIGN_MASK);
        flow_pc_s  = flow_bad_s ? mtvec_addr : flow_target_s;
        event_pc_s = event_target_s;
`else
        flow_bad_s = 1'b0;
        flow_pc_s  = flow_target_s & ALIGN_MASK;
        event_pc_s = event_target_s & ALIGN_MASK;
`endif
        if (event_s) begin
            pc_d = event_pc_s;
        end else begin
            pc_d = flow_pc_s;
        end
    end

    // Control FSM: owns the PC and the registered fetch_valid.
    always_ff @(negedge clk) begin
        if (!x_reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q       <= ST_FETCH;
                    fetch_valid_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (accept_s) begin
                        pc_q <= pc_d;
                    end else if (event_s) begin
                        pc_q          <= event_pc_s;
                        state_q       <= ST_FLUSH;
                        fetch_valid_q <= 1'b0;
                    end else begin
                        pc_q <= pc_q;
                    end
                end
                ST_FLUSH: begin
                    if (trap_req) begin
                        pc_q <= event_pc_s;
                    end else begin
                        state_q       <= ST_FETCH;
                        fetch_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef RISCV_PC_MISALIGN_EN
    logic                   exc_misaligned_q;
    logic [WORD_LENGTH-1:0] exc_badaddr_q;

    // Misalignment exception: one-cycle pulse, offending address held until the next one.
    always_ff @(negedge clk) begin
        if (!x_reset) begin
            exc_misaligned_q <= 1'b0;
            exc_badaddr_q    <= '0;
        end else if ((state_q == ST_FETCH) && accept_s && !event_s && flow_bad_s) begin
            exc_misaligned_q <= 1'b1;
            exc_badaddr_q    <= flow_target_s;
        end else begin
            exc_misaligned_q <= 1'b0;
        end
    end

    assign exc_misaligned = exc_misaligned_q;
    assign exc_badaddr    = exc_badaddr_q;
`else
    assign exc_misaligned = 1'b0;
    assign exc_badaddr    = {WORD_LENGTH{1'b0}};
`endif

    assign fetch_port.fetch_valid = fetch_valid_q;
    assign fetch_port.fetch_addr  = pc_q;
    assign pc_plus4               = pc_q + STEP;

endmodule

// File: tb/tb_riscv_pc_unit.sv
// Directed plus randomized bench for riscv_pc_unit against a rule-level reference model.
module tb_riscv_pc_unit;

    localparam logic [1:0]  SEL_SEQ   = 2'd0;
    localparam logic [1:0]  SEL_ALU   = 2'd1;
    localparam logic [1:0]  SEL_BR    = 2'd2;
    localparam logic [1:0]  SEL_ECALL = 2'd3;
    localparam logic [31:0] RV        = 32'h0000_0100;
    localparam int          P_WAIT    = 0;
    localparam int          P_RUN     = 1;
    localparam int          P_BUBBLE  = 2;

    logic        clk;
    logic        x_reset;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] alu_out;
    logic [31:0] imm_b_sext;
    logic        br_flag;
    logic [31:0] mtvec_addr;
    logic [31:0] mepc_addr;
    logic        trap_req;
    logic        mret_req;
    logic [31:0] pc_plus4;
    logic        exc_misaligned;
    logic [31:0] exc_badaddr;

    int compared;
    int mismatched;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_bad;
    logic        m_valid;
    logic        m_exc;
    int          m_phase;

    riscv_pc_unit_if #(.WORD_LENGTH(32)) fetch_if ();

    riscv_pc_unit #(
        .WORD_LENGTH (32),
        .RESET_VECTOR(RV)
    ) dut (
        .clk           (clk),
        .x_reset       (x_reset),
        .stall         (stall),
        .pc_sel        (pc_sel),
        .alu_out       (alu_out),
        .imm_b_sext    (imm_b_sext),
        .br_flag       (br_flag),
        .mtvec_addr    (mtvec_addr),
        .mepc_addr     (mepc_addr),
        .trap_req      (trap_req),
        .mret_req      (mret_req),
        .fetch_port    (fetch_if.master),
        .pc_plus4      (pc_plus4),
        .exc_misaligned(exc_misaligned),
        .exc_badaddr   (exc_badaddr)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_floor(input logic [31:0] a);
        return a - (a % 32'd4);
    endfunction

    function automatic logic [31:0] event_fix(input logic [31:0] a);
`ifdef RISCV_PC_MISALIGN_EN
        return a;
`else
        return word_floor(a);
`endif
    endfunction

    // Apply the behavioural rules for one active edge using the current inputs.
    task automatic model_step();
        logic [31:0] tgt;
        if (!x_reset) begin
            m_pc = RV; m_valid = 1'b0; m_phase = P_WAIT; m_exc = 1'b0; m_bad = 32'h0;
        end else begin
            m_exc = 1'b0;
            if (m_phase == P_WAIT) begin
                m_phase = P_RUN; m_valid = 1'b1;
            end else if (m_phase == P_BUBBLE) begin
                if (trap_req) m_pc = event_fix(mtvec_addr);
                else begin m_phase = P_RUN; m_valid = 1'b1; end
            end else if (m_valid && fetch_if.fetch_ready && !stall) begin
                if (trap_req) m_pc = event_fix(mtvec_addr);
                else if (mret_req) m_pc = event_fix(mepc_addr);
                else begin
                    if (pc_sel == SEL_ALU) tgt = alu_out - (alu_out % 32'd2);
                    else if (pc_sel == SEL_BR && br_flag) tgt = m_pc + imm_b_sext;
                    else if (pc_sel == SEL_ECALL) tgt = mtvec_addr;
                    else tgt = m_pc + 32'd4;
`ifdef RISCV_PC_MISALIGN_EN
                    if (tgt % 32'd4 != 32'd0) begin
                        m_exc = 1'b1; m_bad = tgt; m_pc = mtvec_addr;
                    end else m_pc = tgt;
`else
                    m_pc = word_floor(tgt);
`endif
                end
            end else if (trap_req || mret_req) begin
                m_pc    = trap_req ? event_fix(mtvec_addr) : event_fix(mepc_addr);
                m_phase = P_BUBBLE;
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        @(posedge clk);
        check("fetch_valid", {31'd0, fetch_if.fetch_valid}, {31'd0, m_valid});
        check("fetch_addr", fetch_if.fetch_addr, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("exc_misaligned", {31'd0, exc_misaligned}, {31'd0, m_exc});
        check("exc_badaddr", exc_badaddr, m_bad);
    endtask

    initial begin
        logic [31:0] r;
        compared = 0; mismatched = 0;
        m_pc = RV; m_valid = 1'b0; m_phase = P_WAIT; m_exc = 1'b0; m_bad = 32'h0;
        x_reset = 1'b0; stall = 1'b0; pc_sel = SEL_SEQ; alu_out = 32'h0;
        imm_b_sext = 32'h0; br_flag = 1'b0; mtvec_addr = 32'h800; mepc_addr = 32'h900;
        trap_req = 1'b0; mret_req = 1'b0; fetch_if.fetch_ready = 1'b1;

        // Reset, then sequential fetch from the reset vector
        tick(); tick();
        x_reset = 1'b1;
        tick(); tick(); tick();

        // Back-pressure with a pending ALU redirect that must be ignored
        fetch_if.fetch_ready = 1'b0; pc_sel = SEL_ALU; alu_out = 32'h555;
        tick(); tick(); tick();
        fetch_if.fetch_ready = 1'b1; pc_sel = SEL_SEQ;
        tick(); tick();

        // Branch taken / not taken from 0x200
        pc_sel = SEL_ALU; alu_out = 32'h201; tick();
        pc_sel = SEL_BR; br_flag = 1'b1; imm_b_sext = 32'hFFFF_FFF8; tick();
        pc_sel = SEL_ALU; alu_out = 32'h200; tick();
        pc_sel = SEL_BR; br_flag = 1'b0; tick();
        pc_sel = SEL_ECALL; tick();
        pc_sel = SEL_SEQ; tick();

        // Stalled trap: one bubble, then resume at mtvec
        stall = 1'b1; trap_req = 1'b1; tick();
        trap_req = 1'b0; stall = 1'b0; tick(); tick();
        // Trap and mret together, accepted and stalled
        trap_req = 1'b1; mret_req = 1'b1; tick();
        stall = 1'b1; tick();
        trap_req = 1'b0; mret_req = 1'b0; stall = 1'b0; tick();
        // Trap during the bubble extends it
        stall = 1'b1; trap_req = 1'b1; mtvec_addr = 32'hA00; tick();
        mtvec_addr = 32'hB00; tick();
        trap_req = 1'b0; stall = 1'b0; tick(); tick();
        // Stalled mret
        stall = 1'b1; mret_req = 1'b1; tick();
        mret_req = 1'b0; stall = 1'b0; tick();

        // Wrap-around and reset during a stall
        pc_sel = SEL_ALU; alu_out = 32'hFFFF_FFFC; tick();
        pc_sel = SEL_SEQ; tick();
        stall = 1'b1; tick();
        x_reset = 1'b0; tick();
        x_reset = 1'b1; stall = 1'b0; tick(); tick();

        // Misaligned ALU target
        mtvec_addr = 32'h800;
        pc_sel = SEL_ALU; alu_out = 32'h302; tick();
        pc_sel = SEL_SEQ; tick(); tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            x_reset = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 3) == 0);
            fetch_if.fetch_ready = ($urandom_range(0, 3) != 0);
            pc_sel = 2'($urandom_range(0, 3));
            alu_out = $urandom;
            r = $urandom;
            imm_b_sext = {{19{r[12]}}, r[12:1], 1'b0};
            br_flag = r[20];
            mtvec_addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            mepc_addr = $urandom;
            trap_req = ($urandom_range(0, 9) == 0);
            mret_req = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
